// File: rtl/cr_adler_mc_if.sv
// Stream interface for the multi-channel Adler-32 engine.
//
// Handshake rules, both directions:
//   A beat moves on a rising clock edge only when valid and ready are both
//   high. The producer keeps valid and every payload signal stable until that
//   edge. Ready may depend combinationally on the consumer's own state and on
//   the opposite ready, never on valid. Payload is ignored whenever valid is low.
interface cr_adler_mc_if #(
    parameter int BYTES = 8,
    parameter int CH_W  = 2
);
    // Input beat channel
    logic                 in_valid;
    logic                 in_ready;
    logic [8*BYTES-1:0]   in_data;
    logic [BYTES-1:0]     in_bytes_valid;
    logic                 in_sof;
    logic                 in_eof;
    logic [CH_W-1:0]      in_chan;
    logic                 seed_en;
    logic [31:0]          in_seed;

    // Result channel
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_W-1:0]      out_chan;
    logic [31:0]          out_adler;
    logic [31:0]          out_len;

    // Traffic source and result sink (testbench or upstream logic)
    modport master (
        output in_valid, in_data, in_bytes_valid, in_sof, in_eof, in_chan,
               seed_en, in_seed, out_ready,
        input  in_ready, out_valid, out_chan, out_adler, out_len
    );

    // Checksum engine
    modport slave (
        input  in_valid, in_data, in_bytes_valid, in_sof, in_eof, in_chan,
               seed_en, in_seed, out_ready,
        output in_ready, out_valid, out_chan, out_adler, out_len
    );
endinterface

// File: rtl/cr_adler_mc.sv
// Multi-channel streaming Adler-32 engine. Each channel keeps its own A, B and
// byte count, so interleaved beats from different flows are absorbed at one
// beat per cycle. A whole beat (up to BYTES enabled lanes, any mask pattern)
// is folded into the running sums in a single cycle, and finished checksums
// are parked in a one-entry result register with valid/ready backpressure.
module cr_adler_mc #(
    parameter int BYTES    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic          clk,
    input logic          rst,
    cr_adler_mc_if.slave bus
);
    localparam logic [16:0] MOD17      = 17'd65521;
    localparam int          KW         = $clog2(BYTES + 1);
    localparam logic [31:0] CHANNELS_U = CHANNELS;

    // Reduce a 16-bit seed half into the residue range with one subtract.
    function automatic logic [15:0] reduce_seed(input logic [15:0] x);
        return (17'(x) >= MOD17) ? 16'(17'(x) - MOD17) : x;
    endfunction

    // Exact mod 65521 of the B accumulator: 2^16 == 15 (mod 65521), so the
    // upper bits fold down as hi*15. For sums below 2^26 the folded value is
    // under 2*65521, so one conditional subtract finishes the reduction.
    function automatic logic [15:0] reduce_b(input logic [25:0] x);
        logic [16:0] t;
        t = 17'(x[15:0]) + 17'(x[25:16]) * 17'd15;
        return (t >= MOD17) ? 16'(t - MOD17) : t[15:0];
    endfunction

    // Per-channel checksum contexts; A and B are always held below 65521.
    logic [15:0] ctx_a   [CHANNELS];
    logic [15:0] ctx_b   [CHANNELS];
    logic [31:0] ctx_len [CHANNELS];

    logic        accept;
    logic        ch_ok;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [31:0] l0;
    logic [KW-1:0] k;
    logic [16:0] a_sum;
    logic [25:0] b_sum;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [31:0] l1;

    // One result slot: a new beat is only taken when the slot is free or is
    // being drained this cycle, which stalls every channel together.
    assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign ch_ok        = (32'(bus.in_chan) < CHANNELS_U);

    // Pick the starting context: fresh (optionally seeded) on sof, otherwise
    // whatever the channel has accumulated so far.
    always_comb begin
        a0 = 16'd1;
        b0 = 16'd0;
        l0 = 32'd0;
        if (bus.in_sof) begin
            if (bus.seed_en) begin
                a0 = reduce_seed(bus.in_seed[15:0]);
                b0 = reduce_seed(bus.in_seed[31:16]);
            end
        end else if (ch_ok) begin
            a0 = ctx_a[bus.in_chan];
            b0 = ctx_b[bus.in_chan];
            l0 = ctx_len[bus.in_chan];
        end
    end

    // Fold the beat in one step. Walking lanes from the top down, the running
    // count k equals the number of enabled lanes at or above lane i, which is
    // exactly the weight that byte carries into B when bytes are processed in
    // ascending lane order. Disabled lanes contribute nothing.
    always_comb begin
        k     = '0;
        a_sum = 17'(a0);
        b_sum = 26'(b0);
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (bus.in_bytes_valid[i]) begin
                k     = k + KW'(1);
                a_sum = a_sum + 17'(bus.in_data[8*i +: 8]);
                b_sum = b_sum + 26'(k) * 26'(bus.in_data[8*i +: 8]);
            end
        end
        b_sum = b_sum + 26'(k) * 26'(a0);
        a1    = (a_sum >= MOD17) ? 16'(a_sum - MOD17) : a_sum[15:0];
        b1    = reduce_b(b_sum);
        l1    = l0 + 32'(k);
    end

    // Context write-back and result register. A finished message loads the
    // result slot and leaves its channel ready for a fresh message.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ctx_a[c]   <= 16'd1;
                ctx_b[c]   <= 16'd0;
                ctx_len[c] <= 32'd0;
            end
            bus.out_valid <= 1'b0;
            bus.out_chan  <= '0;
            bus.out_adler <= 32'd0;
            bus.out_len   <= 32'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept && ch_ok) begin
                if (bus.in_eof) begin
                    ctx_a[bus.in_chan]   <= 16'd1;
                    ctx_b[bus.in_chan]   <= 16'd0;
                    ctx_len[bus.in_chan] <= 32'd0;
                    bus.out_valid        <= 1'b1;
                    bus.out_chan         <= bus.in_chan;
                    bus.out_adler        <= {b1, a1};
                    bus.out_len          <= l1;
                end else begin
                    ctx_a[bus.in_chan]   <= a1;
                    ctx_b[bus.in_chan]   <= b1;
                    ctx_len[bus.in_chan] <= l1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cr_adler_mc.sv
// Self-checking bench for cr_adler_mc: reset state, a table of one-beat
// messages with hand-derived checksums, multi-beat and seeded sequences,
// long interleaved and random traffic against a byte-serial Adler-32 model,
// and reset in the middle of a message.
module tb_cr_adler_mc;
    localparam int BYTES    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;
    localparam int W        = CH_W + 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_adler_mc_if #(.BYTES(BYTES), .CH_W(CH_W)) bus ();

    cr_adler_mc #(.BYTES(BYTES), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int unsigned m_a[CHANNELS];
    int unsigned m_b[CHANNELS];
    int unsigned m_len[CHANNELS];
    int ready_mode = 0;   // 0: always ready, 1: random (30% low), 2: never
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] adler_bytes(input logic [7:0] q[$], input logic [31:0] start);
        int unsigned a, b;
        a = start[15:0] % 65521;
        b = start[31:16] % 65521;
        foreach (q[i]) begin
            a = (a + q[i]) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_a[c] = 1; m_b[c] = 0; m_len[c] = 0;
        end
    endtask

    task automatic model_beat(input int ch, input logic [63:0] d, input logic [7:0] m,
                              input bit sof, input bit eof, input bit se, input logic [31:0] seed);
        if (ch >= CHANNELS) return;
        if (sof) begin
            m_a[ch] = se ? seed[15:0] % 65521 : 1;
            m_b[ch] = se ? seed[31:16] % 65521 : 0;
            m_len[ch] = 0;
        end
        for (int i = 0; i < BYTES; i++) begin
            if (m[i]) begin
                m_a[ch] = (m_a[ch] + d[8*i +: 8]) % 65521;
                m_b[ch] = (m_b[ch] + m_a[ch]) % 65521;
                m_len[ch] = m_len[ch] + 1;
            end
        end
        if (eof) begin
            exp_q.push_back({CH_W'(ch), m_b[ch][15:0], m_a[ch][15:0], m_len[ch]});
            m_a[ch] = 1; m_b[ch] = 0; m_len[ch] = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int ch, input logic [63:0] d, input logic [7:0] m,
                        input bit sof, input bit eof, input bit se, input logic [31:0] seed);
        int guard;
        @(negedge clk);
        bus.in_valid       = 1'b1;
        bus.in_chan        = CH_W'(ch);
        bus.in_data        = d;
        bus.in_bytes_valid = m;
        bus.in_sof         = sof;
        bus.in_eof         = eof;
        bus.seed_en        = se;
        bus.in_seed        = seed;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_beat(ch, d, m, sof, eof, se, seed);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output logic [W-1:0] r);
        int guard;
        guard = 0;
        r = '0;
        while (got_q.size() == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got none expected a result at %0t", name, $time);
        end else begin
            r = got_q.pop_front();
        end
    endtask

    // ---------------- result monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] held;
        logic [W-1:0] cur;
        logic [W-1:0] e;
        bit stalled;
        bit r;
        stalled = 1'b0;
        held = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                stalled = 1'b0;
            end else begin
                cur = {bus.out_chan, bus.out_adler, bus.out_len};
                if (stalled) begin
                    check("stall_valid", W'(bus.out_valid), W'(1));
                    check("stall_hold", cur, held);
                end
                case (ready_mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 9) >= 3);
                    default: r = 1'b0;
                endcase
                bus.out_ready = r;
                stalled = 1'b0;
                if (bus.out_valid) begin
                    if (r) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_result: got %h expected none", cur);
                        end else begin
                            e = exp_q.pop_front();
                            check("model_result", cur, e);
                        end
                        got_q.push_back(cur);
                    end else begin
                        stalled = 1'b1;
                        held = cur;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int          chan;
        logic [63:0] data;
        logic [7:0]  mask;
        bit          seed_en;
        logic [31:0] seed;
        logic [31:0] exp_adler;
        logic [31:0] exp_len;
    } vec_t;

    vec_t vt[10];

    initial begin : main
        logic [W-1:0] r;
        logic [31:0]  wiki_r;
        logic [7:0]   wiki_q[$];
        int guard;

        vt[0] = '{1, 64'h0,                 8'h00, 1'b0, 32'h0,        32'h00000001, 32'd0};
        vt[1] = '{2, 64'h3F6261,            8'h03, 1'b0, 32'h0,        32'h012600C4, 32'd2};
        vt[2] = '{3, 64'h623F61,            8'h05, 1'b0, 32'h0,        32'h012600C4, 32'd2};
        vt[3] = '{0, 64'h636261,            8'h07, 1'b0, 32'h0,        32'h024D0127, 32'd3};
        vt[4] = '{1, 64'h61,                8'h01, 1'b0, 32'h0,        32'h00620062, 32'd1};
        vt[5] = '{2, 64'h0,                 8'h00, 1'b1, 32'hFFFFFFFF, 32'h000E000E, 32'd0};
        vt[6] = '{3, 64'h61,                8'h01, 1'b1, 32'hFFFFFFFF, 32'h007D006F, 32'd1};
        vt[7] = '{0, 64'hFFFFFFFFFFFFFFFF,  8'hFF, 1'b0, 32'h0,        32'h23E407F9, 32'd8};
        vt[8] = '{1, 64'h6100000000000000,  8'h80, 1'b0, 32'h0,        32'h00620062, 32'd1};
        vt[9] = '{2, 64'h61,                8'h01, 1'b1, 32'h00050003, 32'h00690064, 32'd1};

        bus.in_valid = 1'b0;
        bus.in_chan = '0;
        bus.in_data = '0;
        bus.in_bytes_valid = '0;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
        bus.seed_en = 1'b0;
        bus.in_seed = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", W'(bus.in_ready), W'(0));
        check("rst_out", {1'b0, bus.out_valid, bus.out_chan, bus.out_adler, bus.out_len}[W-1:0], '0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", W'(bus.in_ready), W'(1));
        mon_en = 1'b1;

        // Table of one-beat messages
        for (int t = 0; t < 10; t++) begin
            send(vt[t].chan, vt[t].data, vt[t].mask, 1'b1, 1'b1, vt[t].seed_en, vt[t].seed);
            idle();
            wait_result($sformatf("vec%0d", t), r);
            check($sformatf("vec%0d", t), r, {CH_W'(vt[t].chan), vt[t].exp_adler, vt[t].exp_len});
        end

        // Two-beat "Wikipedia" on back-to-back cycles
        send(0, 64'h69646570696B6957, 8'hFF, 1'b1, 1'b0, 1'b0, 32'h0);
        send(0, 64'h61, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        wait_result("wikipedia", r);
        check("wikipedia", r, {2'd0, 32'h11E60398, 32'd9});

        // Continuation: "Wiki" then "pedia" seeded with the reference "Wiki" sum
        wiki_q = '{8'h57, 8'h69, 8'h6B, 8'h69};
        wiki_r = adler_bytes(wiki_q, 32'h00000001);
        send(0, 64'h696B6957, 8'h0F, 1'b1, 1'b1, 1'b0, 32'h0);
        idle();
        wait_result("wiki", r);
        check("wiki", r, {2'd0, wiki_r, 32'd4});
        send(0, 64'h6169646570, 8'h1F, 1'b1, 1'b1, 1'b1, wiki_r);
        idle();
        wait_result("pedia_seeded", r);
        check("pedia_seeded", r, {2'd0, 32'h11E60398, 32'd5});

        // sof mid-message discards old state; eof without sof starts fresh
        send(1, 64'h7A7978, 8'h07, 1'b1, 1'b0, 1'b0, 32'h0);
        send(1, 64'h6261, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0);
        send(2, 64'h636261, 8'h07, 1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        wait_result("resof", r);
        check("resof", r, {2'd1, 32'h012600C4, 32'd2});
        wait_result("nosof", r);
        check("nosof", r, {2'd2, 32'h024D0127, 32'd3});

        // 64 KiB of 0xFF per channel, all four interleaved, random backpressure
        got_q.delete();
        ready_mode = 1;
        for (int j = 0; j < 8192; j++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                send(c, 64'hFFFFFFFFFFFFFFFF, 8'hFF, j == 0, j == 8191, 1'b0, 32'h0);
            end
        end
        idle();
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("long_count", W'(got_q.size()), W'(CHANNELS));
        for (int c = 0; c < CHANNELS && got_q.size() > 0; c++) begin
            r = got_q.pop_front();
            check($sformatf("long_ch%0d", c), r, {CH_W'(c), 32'h77970EF2, 32'd65536});
        end

        // Random beats against the model
        for (int n = 0; n < 400; n++) begin
            send($urandom_range(0, CHANNELS - 1), {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? 32'hFFF5FFF8 : $urandom);
        end
        idle();
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);
        got_q.delete();

        // Reset mid-message with a result pending
        ready_mode = 2;
        repeat (2) @(negedge clk);
        send(0, 64'h7A7978, 8'h07, 1'b1, 1'b0, 1'b0, 32'h0);
        send(1, 64'h61, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0);
        idle();
        #2 rst = 1'b1;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", W'(bus.in_ready), W'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check("after_rst_out_valid", W'(bus.out_valid), W'(0));
        ready_mode = 0;
        send(0, 64'h61, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0);
        send(0, 64'h61, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0);
        idle();
        wait_result("rst_fresh", r);
        check("rst_fresh", r, {2'd0, 32'h00620062, 32'd1});
        wait_result("rst_sof", r);
        check("rst_sof", r, {2'd0, 32'h00620062, 32'd1});

        // Nothing left over
        repeat (5) @(negedge clk);
        check("exp_q_empty", W'(exp_q.size()), W'(0));
        check("got_q_empty", W'(got_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
